// File: rtl/cacheline_adaptor.sv
// Bridges single-cycle 256-bit cache line transfers to four-beat 64-bit pmem bursts.
// One shared line buffer and beat counter serve both fills and writebacks.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64,
  parameter int n_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int CNT_W = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam int OFF_W = $clog2(s_line / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(n_beats - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [s_line-1:0]   line_buf;
  logic [31:OFF_W]     addr_q;
  logic                unused_addr_bits;

  // Byte-offset bits never reach pmem; only the line-aligned part is kept.
  assign unused_addr_bits = ^address_i[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write_i) begin
          state_next = WRITE;
        end else if (read_i) begin
          state_next = READ;
        end
      end
      READ, WRITE: begin
        if (resp_i && (cnt == LAST)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      line_buf <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            addr_q   <= address_i[31:OFF_W];
            line_buf <= line_i;
            cnt      <= '0;
          end else if (read_i) begin
            addr_q <= address_i[31:OFF_W];
            cnt    <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_buf[int'(cnt)*s_burst +: s_burst] <= burst_i;
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus controls decode registered state only, so no request input leaks through.
  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state)
      READ:  read_o = 1'b1;
      WRITE: begin
        write_o = 1'b1;
        burst_o = line_buf[int'(cnt)*s_burst +: s_burst];
      end
      DONE:  resp_o = 1'b1;
      default: begin
      end
    endcase
  end

  assign line_o    = line_buf;
  assign address_o = {addr_q, {OFF_W{1'b0}}};

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model is compared every
// cycle, and hand-computed literals pin the key scenarios.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int errors = 0;
  int checks = 0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: a pending line fill or writeback, beats moved so far,
  // and a completion flag for the cycle after the last beat.
  logic        m_rd, m_wr, m_resp;
  int          m_beats;
  logic [31:0] m_addr;
  logic [63:0] m_w [4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rd <= 1'b0; m_wr <= 1'b0; m_resp <= 1'b0; m_beats <= 0; m_addr <= '0;
      for (int i = 0; i < 4; i++) m_w[i] <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_rd || m_wr) begin
      if (resp_i) begin
        if (m_rd) m_w[m_beats] <= burst_i;
        if (m_beats == 3) begin
          m_rd <= 1'b0; m_wr <= 1'b0; m_resp <= 1'b1; m_beats <= 0;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end else if (write_i) begin
      m_wr <= 1'b1; m_addr <= address_i; m_beats <= 0;
      for (int i = 0; i < 4; i++) m_w[i] <= line_i[i*64 +: 64];
    end else if (read_i) begin
      m_rd <= 1'b1; m_addr <= address_i; m_beats <= 0;
    end
  end

  always @(negedge clk) begin
    check("m_read_o", read_o, m_rd);
    check("m_write_o", write_o, m_wr);
    check("m_resp_o", resp_o, m_resp);
    check("m_address_o", address_o, {m_addr[31:5], 5'b0});
    check("m_line_o", line_o, {m_w[3], m_w[2], m_w[1], m_w[0]});
    if (m_wr) check("m_burst_o", burst_o, m_w[m_beats]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] eb [7];
  int          rp [7];
  int          cnt_rd;
  logic        seen;
  int          pulses;
  int          pcyc [2];
  logic [255:0] plines [2];
  logic [255:0] l3;

  initial begin
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    burst_i = '0; line_i = '0; address_i = '0;
    repeat (2) tick();
    check("rst_resp", resp_o, 1'b0);
    check("rst_read", read_o, 1'b0);
    check("rst_addr", address_o, 32'h0);
    check("rst_line", line_o, 256'h0);
    rst = 1'b1;

    // Read with no wait states
    address_i = 32'h0000_1234; read_i = 1'b1;
    tick();
    check("t1_addr", address_o, 32'h0000_1220);
    cnt_rd = 0;
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1; burst_i = 64'h1111_1111_1111_1111 * (k + 1);
      if (read_o) cnt_rd++;
      tick();
    end
    resp_i = 1'b0;
    check("t1_read_cycles", cnt_rd, 4);
    check("t1_resp", resp_o, 1'b1);
    check("t1_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    read_i = 1'b0;
    tick();
    check("t1_resp_drop", resp_o, 1'b0);

    // Write with wait states; inputs scrambled after acceptance
    address_i = 32'h0000_8011; write_i = 1'b1;
    line_i = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    tick();
    write_i = 1'b0; line_i = '0; address_i = 32'hDEAD_BEEF;
    rp = '{1, 0, 0, 1, 1, 0, 1};
    eb = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hBBBB_BBBB_BBBB_BBBB,
           64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD,
           64'hDDDD_DDDD_DDDD_DDDD};
    for (int c = 0; c < 7; c++) begin
      resp_i = rp[c][0];
      check("t2_burst", burst_o, eb[c]);
      check("t2_no_resp", resp_o, 1'b0);
      tick();
    end
    resp_i = 1'b0;
    check("t2_resp", resp_o, 1'b1);
    check("t2_addr", address_o, 32'h0000_8000);
    tick();
    check("t2_resp_once", resp_o, 1'b0);

    // Simultaneous requests: write wins
    l3 = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
          64'h0101_0101_0101_0101, 64'h0F0F_0F0F_0F0F_0F0F};
    address_i = 32'h0000_4460; line_i = l3; read_i = 1'b1; write_i = 1'b1;
    tick();
    check("t3_write", write_o, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      seen |= read_o;
      tick();
    end
    resp_i = 1'b0;
    check("t3_no_read", seen, 1'b0);
    check("t3_resp", resp_o, 1'b1);
    read_i = 1'b0; write_i = 1'b0;
    tick();

    // Spurious resp_i and address in IDLE
    address_i = 32'h0000_00FF; resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (3) tick();
    resp_i = 1'b0;
    check("t4_addr_kept", address_o, 32'h0000_4460);
    check("t4_line_kept", line_o, l3);

    // Reset mid-read
    address_i = 32'h0000_2000; read_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = 64'hEEEE_0000_0000_0000 + 64'(k);
      tick();
    end
    resp_i = 1'b0; read_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t5_read", read_o, 1'b0);
    check("t5_resp", resp_o, 1'b0);
    check("t5_addr", address_o, 32'h0);
    check("t5_line", line_o, 256'h0);
    check("t5_burst", burst_o, 64'h0);
    tick();
    check("t5_resp_held", resp_o, 1'b0);
    rst = 1'b1; address_i = 32'h0000_3040; read_i = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1; burst_i = 64'h6000_0000_0000_0000 + 64'(k);
      tick();
    end
    resp_i = 1'b0; read_i = 1'b0;
    check("t5_resp_new", resp_o, 1'b1);
    check("t5_addr_new", address_o, 32'h0000_3040);
    check("t5_line_new", line_o, {64'h6000_0000_0000_0003, 64'h6000_0000_0000_0002,
                                  64'h6000_0000_0000_0001, 64'h6000_0000_0000_0000});
    tick();

    // Back-to-back reads with read_i held through resp_o
    address_i = 32'h0000_7000; read_i = 1'b1; resp_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30 && pulses < 2; c++) begin
      burst_i = 64'hC000_0000_0000_0000 + 64'(c);
      tick();
      if (resp_o) begin
        pcyc[pulses] = c;
        plines[pulses] = line_o;
        pulses++;
        if (pulses == 2) read_i = 1'b0;
      end
    end
    resp_i = 1'b0; read_i = 1'b0;
    check("t6_pulses", pulses, 2);
    if (pulses == 2) begin
      check("t6_spacing", pcyc[1] - pcyc[0], 6);
      check("t6_line0", plines[0], {64'hC000_0000_0000_0004, 64'hC000_0000_0000_0003,
                                    64'hC000_0000_0000_0002, 64'hC000_0000_0000_0001});
      check("t6_line1", plines[1], {64'hC000_0000_0000_000A, 64'hC000_0000_0000_0009,
                                    64'hC000_0000_0000_0008, 64'hC000_0000_0000_0007});
    end
    repeat (2) tick();
    check("t6_idle", read_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
